// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and request record for the register-file write-port arbiter.
package regfile_arb_pkg;
  localparam int NREQ_MAX = 4;
  localparam int AW       = 5;
  localparam int DW       = 64;
  localparam logic [AW-1:0] ZR_IDX = 5'd31;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Write-back requester bundle: per-requester valid/ready plus destination and data.
interface regfile_wr_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 64
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][DW-1:0] req_data;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_wr_arbiter_rr_picker.sv
// Round-robin picker: first valid requester at or above ptr, wrapping modulo NREQ.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);
  logic [PW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = PW'((int'(ptr) + k) % NREQ);
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single regfile write port, with registered we3/wa3/wd3.
// Optional pending-write scoreboard (busy1/busy2) built when REGFILE_ARB_SCOREBOARD_EN is defined.
module regfile_wr_arbiter
  import regfile_arb_pkg::ZR_IDX;
#(
  parameter int NREQ = 2,
  parameter int DW   = 64,
  parameter int AW   = 5,
  parameter int ZR   = int'(ZR_IDX)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  regfile_wr_arbiter_if.slave   req,
  output logic                  we3,
  output logic [AW-1:0]         wa3,
  output logic [DW-1:0]         wd3,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr,
  input  logic [AW-1:0]         ra1,
  input  logic [AW-1:0]         ra2,
  output logic                  busy1,
  output logic                  busy2
);
  localparam int PW = $clog2(NREQ);
  localparam logic [AW-1:0] ZR_A = AW'(ZR);

  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] pick_grant;
  logic [PW-1:0]   win_idx;
  logic            pick_any;
  logic            accept;

  rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
    .valid (req.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (win_idx),
    .any   (pick_any)
  );

  // Grants are suppressed in reset and stall so no handshake completes then.
  assign accept        = pick_any && !stall && reset_n;
  assign req.req_ready = accept ? pick_grant : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      we3    <= 1'b0;
      wa3    <= '0;
      wd3    <= '0;
    end else if (accept) begin
      rr_ptr <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
      wa3    <= req.req_addr[win_idx];
      wd3    <= req.req_data[win_idx];
      we3    <= (req.req_addr[win_idx] != ZR_A);
    end else begin
      we3    <= 1'b0;
    end
  end

`ifdef REGFILE_ARB_SCOREBOARD_EN
  localparam int NREG = 1 << AW;
  logic [NREG-1:0] pending, pending_nxt;

  // Clear for the retiring write first so a same-edge set on that register wins.
  always_comb begin
    pending_nxt = pending;
    if (we3)
      pending_nxt[wa3] = 1'b0;
    if (sb_set && sb_addr != ZR_A)
      pending_nxt[sb_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) pending <= '0;
    else          pending <= pending_nxt;
  end

  assign busy1 = pending[ra1] && (ra1 != ZR_A);
  assign busy2 = pending[ra2] && (ra2 != ZR_A);
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set, sb_addr, ra1, ra2};
  assign busy1     = 1'b0;
  assign busy2     = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: driver pushes expected writes, monitor checks the write port.
module tb_regfile_wr_arbiter;
  import regfile_arb_pkg::*;

  logic          clk = 1'b0;
  logic          reset_n, stall, sb_set;
  logic [AW-1:0] sb_addr, ra1, ra2;
  logic          we3, busy1, busy2;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;

  int checks   = 0;
  int failures = 0;
  wb_req_t exp_q[$];
  logic [DW-1:0] rf [0:31];

  regfile_wr_arbiter_if #(.NREQ(2), .AW(AW), .DW(DW)) rif ();

  regfile_wr_arbiter #(.NREQ(2), .DW(DW), .AW(AW), .ZR(31)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .req(rif.slave),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .sb_set(sb_set), .sb_addr(sb_addr), .ra1(ra1), .ra2(ra2),
    .busy1(busy1), .busy2(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every write seen on the port must match the oldest expected write.
  always @(negedge clk) begin
    if (we3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=wa3:%0h wd3:%0h required=none", wa3, wd3);
      end else begin
        wb_req_t e;
        e = exp_q.pop_front();
        chk("wa3", 64'(wa3), 64'(e.addr));
        chk("wd3", wd3, e.data);
      end
    end
  end

  always @(posedge clk) if (we3 === 1'b1) rf[wa3] <= wd3;

  task automatic drv(input logic [1:0] v, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    rif.req_valid   = v;
    rif.req_addr[0] = a0;
    rif.req_data[0] = d0;
    rif.req_addr[1] = a1;
    rif.req_data[1] = d1;
  endtask

  // Check ready at the negedge and queue the write each hand-predicted grant should produce.
  task automatic expect_ready(input string nm, input logic [1:0] exp);
    wb_req_t e;
    chk(nm, 64'(rif.req_ready), 64'(exp));
    for (int i = 0; i < 2; i++)
      if (exp[i] && rif.req_addr[i] != ZR_IDX) begin
        e.addr = rif.req_addr[i];
        e.data = rif.req_data[i];
        exp_q.push_back(e);
      end
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; sb_set = 1'b0; sb_addr = '0; ra1 = '0; ra2 = '0;
    drv(2'b11, 5'd1, 64'h11, 5'd2, 64'h22);
    @(negedge clk); expect_ready("rst_ready_a", 2'b00); to_next();
    @(negedge clk); expect_ready("rst_ready_b", 2'b00); chk("rst_we3", 64'(we3), 0); to_next();
    chk("rst_wa3", 64'(wa3), 0);
    chk("rst_wd3", wd3, 0);

    reset_n = 1'b1; ra1 = 5'd7; ra2 = 5'd0;
    drv(2'b00, 5'd1, 64'h11, 5'd2, 64'h22);
    @(negedge clk);
    chk("rst_busy1", 64'(busy1), 0);
    chk("rst_busy2", 64'(busy2), 0);
    expect_ready("idle_ready", 2'b00);
    to_next();

    // Single requester
    drv(2'b01, 5'd5, 64'hA5, 5'd2, 64'h22);
    @(negedge clk); expect_ready("single_ready", 2'b01); to_next();
    drv(2'b00, 5'd5, 64'hA5, 5'd2, 64'h22);
    @(negedge clk); chk("single_we3", 64'(we3), 1); to_next();
    chk("rf_x5", rf[5], 64'hA5);

    // Zero-register write: handshake completes, no regfile write
    drv(2'b10, 5'd5, 64'hA5, 5'd31, 64'hFF);
    @(negedge clk); expect_ready("zr_ready", 2'b10); to_next();
    drv(2'b00, 5'd5, 64'hA5, 5'd31, 64'hFF);
    @(negedge clk); chk("zr_we3", 64'(we3), 0); to_next();

    // Contention from rr_ptr=0
    drv(2'b11, 5'd1, 64'h11, 5'd2, 64'h22);
    @(negedge clk); expect_ready("cont_0", 2'b01); to_next();
    @(negedge clk); expect_ready("cont_1", 2'b10); to_next();
    @(negedge clk); expect_ready("cont_2", 2'b01); to_next();
    @(negedge clk); expect_ready("cont_3", 2'b10); to_next();

    // Move rr_ptr to 1, then stall and release
    drv(2'b01, 5'd3, 64'h33, 5'd2, 64'h22);
    @(negedge clk); expect_ready("pre_stall", 2'b01); to_next();
    stall = 1'b1;
    drv(2'b11, 5'd1, 64'h11, 5'd2, 64'h22);
    @(negedge clk); expect_ready("stall_0", 2'b00); to_next();
    @(negedge clk); expect_ready("stall_1", 2'b00); chk("stall_we3_1", 64'(we3), 0); to_next();
    @(negedge clk); expect_ready("stall_2", 2'b00); chk("stall_we3_2", 64'(we3), 0); to_next();
    stall = 1'b0;
    @(negedge clk); expect_ready("release", 2'b10); to_next();

    // Reset mid-operation returns rr_ptr to 0
    drv(2'b01, 5'd4, 64'h44, 5'd2, 64'h22);
    @(negedge clk); expect_ready("pre_rst", 2'b01); to_next();
    reset_n = 1'b0;
    drv(2'b11, 5'd1, 64'h11, 5'd2, 64'h22);
    @(negedge clk); expect_ready("mid_rst", 2'b00); to_next();
    reset_n = 1'b1;
    @(negedge clk); chk("post_rst_we3", 64'(we3), 0); expect_ready("post_rst", 2'b01); to_next();
    drv(2'b00, 5'd1, 64'h11, 5'd2, 64'h22);
    @(negedge clk); to_next();

`ifdef REGFILE_ARB_SCOREBOARD_EN
    ra1 = 5'd7; ra2 = 5'd31;
    sb_set = 1'b1; sb_addr = 5'd7;
    @(negedge clk); chk("sb_before", 64'(busy1), 0); to_next();
    sb_set = 1'b0;
    drv(2'b01, 5'd7, 64'h77, 5'd2, 64'h22);
    @(negedge clk); chk("sb_busy1", 64'(busy1), 1); chk("sb_busy2_zr", 64'(busy2), 0);
    expect_ready("sb_wr", 2'b01); to_next();
    drv(2'b00, 5'd7, 64'h77, 5'd2, 64'h22);
    @(negedge clk); chk("sb_busy_we3", 64'(busy1), 1); to_next();
    @(negedge clk); chk("sb_cleared", 64'(busy1), 0); to_next();

    sb_set = 1'b1; sb_addr = 5'd7;
    to_next();
    sb_set = 1'b0;
    drv(2'b01, 5'd7, 64'h78, 5'd2, 64'h22);
    @(negedge clk); expect_ready("sb_wr2", 2'b01); to_next();
    drv(2'b00, 5'd7, 64'h78, 5'd2, 64'h22);
    sb_set = 1'b1; sb_addr = 5'd7;
    @(negedge clk); chk("sb_busy_we3_2", 64'(busy1), 1); to_next();
    sb_set = 1'b0;
    @(negedge clk); chk("sb_set_wins", 64'(busy1), 1); to_next();

    sb_set = 1'b1; sb_addr = 5'd31;
    to_next();
    sb_set = 1'b0;
    @(negedge clk); chk("sb_zr_busy2", 64'(busy2), 0); to_next();
    reset_n = 1'b0;
    to_next();
    reset_n = 1'b1;
    @(negedge clk); chk("sb_rst_clear", 64'(busy1), 0); to_next();
`else
    ra1 = 5'd7; ra2 = 5'd7;
    sb_set = 1'b1; sb_addr = 5'd7;
    to_next();
    sb_set = 1'b0;
    @(negedge clk);
    chk("nosb_busy1", 64'(busy1), 0);
    chk("nosb_busy2", 64'(busy2), 0);
    to_next();
`endif

    @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
